// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants for the single-digit BCD adder
package bcd_pkg;
    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational BCD digit add with decimal correction and range check
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               err
);
    logic [DIGIT_W:0] t;
    always_comb begin
        err  = (a > BCD_MAX) || (b > BCD_MAX);
        t    = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        cout = !err && (t > {1'b0, BCD_MAX});
        // adding 6 modulo 16 maps 10..19 onto 0..9
        sum  = err ? '0 : cout ? t[DIGIT_W-1:0] + BCD_CORR : t[DIGIT_W-1:0];
    end
endmodule

// File: rtl/bcd_adder.sv
// bcd_adder: registered single-digit BCD adder with one-cycle valid pipeline
module bcd_adder
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               carry_in,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] sum,
    output logic               carry,
    output logic               err
);
    logic [DIGIT_W-1:0] d_sum;
    logic               d_cout;
    logic               d_err;

    bcd_digit_add u_add (
        .a   (a),
        .b   (b),
        .cin (carry_in),
        .sum (d_sum),
        .cout(d_cout),
        .err (d_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= d_sum;
                carry <= d_cout;
                err   <= d_err;
            end
        end
    end
endmodule

// File: tb/tb_bcd_adder.sv
// tb_bcd_adder: directed and randomized checks of bcd_adder against a decimal reference model
module tb_bcd_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       carry_in = 1'b0;
    logic       out_valid;
    logic [3:0] sum;
    logic       carry;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;

    logic       m_v = 1'b0;
    logic       m_c = 1'b0;
    logic       m_e = 1'b0;
    logic [3:0] m_s = '0;

    bcd_adder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .out_valid(out_valid),
        .sum      (sum),
        .carry    (carry),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of stimulus, update the decimal model, then check after the edge
    task automatic op(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                      input logic tv, input logic tr);
        int total;
        rst      = tr;
        in_valid = tv;
        a        = ta;
        b        = tb_;
        carry_in = tc;
        total    = int'(ta) + int'(tb_) + int'(tc);
        if (tr) begin
            m_v = 1'b0; m_s = '0; m_c = 1'b0; m_e = 1'b0;
        end else begin
            m_v = tv;
            if (tv) begin
                if (ta > 9 || tb_ > 9) begin
                    m_e = 1'b1; m_s = '0; m_c = 1'b0;
                end else begin
                    m_e = 1'b0;
                    m_c = total >= 10;
                    m_s = 4'(total % 10);
                end
            end
        end
        @(negedge clk);
        chk("model_out_valid", {7'd0, out_valid}, {7'd0, m_v});
        chk("model_sum", {4'd0, sum}, {4'd0, m_s});
        chk("model_carry", {7'd0, carry}, {7'd0, m_c});
        chk("model_err", {7'd0, err}, {7'd0, m_e});
    endtask

    int sa[5] = '{5, 3, 4, 8, 9};
    int sb[5] = '{9, 3, 5, 2, 9};
    int sc[5] = '{0, 1, 0, 0, 1};
    int es[5] = '{4, 7, 9, 0, 9};
    int ec[5] = '{1, 0, 0, 1, 1};

    initial begin
        op(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        op(4'd7, 4'd7, 1'b1, 1'b1, 1'b1);
        chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
        chk("reset_sum", {4'd0, sum}, 8'd0);
        chk("reset_carry_err", {6'd0, carry, err}, 8'd0);

        op(4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("zero_add", {out_valid, err, carry, 1'b0, sum}, 8'b1000_0000);

        for (int i = 0; i < 5; i++) begin
            op(4'(sa[i]), 4'(sb[i]), 1'(sc[i]), 1'b1, 1'b0);
            chk("seq_valid", {7'd0, out_valid}, 8'd1);
            chk("seq_sum", {4'd0, sum}, 8'(es[i]));
            chk("seq_carry", {7'd0, carry}, 8'(ec[i]));
        end

        op(4'd12, 4'd3, 1'b0, 1'b1, 1'b0);
        chk("illegal_digit", {out_valid, err, carry, 1'b0, sum}, 8'b1100_0000);

        op(4'd9, 4'd9, 1'b0, 1'b1, 1'b1);
        chk("rst_discard_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_discard_sum", {4'd0, sum}, 8'd0);

        op(4'd4, 4'd3, 1'b0, 1'b1, 1'b0);
        chk("first_after_rst", {out_valid, 3'd0, sum}, 8'h87);
        op(4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
        chk("pulse_drop", {out_valid, 3'd0, sum}, 8'h07);
        op(4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        chk("hold_sum", {out_valid, 3'd0, sum}, 8'h07);

        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++)
                for (int c = 0; c < 2; c++) begin
                    op(4'(x), 4'(y), 1'(c), 1'b1, 1'b0);
                    chk("sweep_total", 8'(10 * int'(carry) + int'(sum)), 8'(x + y + c));
                end

        for (int i = 0; i < 300; i++) begin
            logic [3:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_adder.md
BCD_ADDER -- requirements
Module: bcd_adder

Interface
REQ-001 The block SHALL have no parameters; the digit width is fixed at 4 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-004 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-005 Port `in_valid`: input, 1 bit, qualifies `a`, `b` and `carry_in` in the current cycle.
REQ-006 Port `a`: input, 4 bits, BCD addend digit (legal range 0-9).
REQ-007 Port `b`: input, 4 bits, BCD addend digit (legal range 0-9).
REQ-008 Port `carry_in`: input, 1 bit, decimal carry into the digit.
REQ-009 Port `out_valid`: output, 1 bit, marks `sum`, `carry` and `err` as holding a new result.
REQ-010 Port `sum`: output, 4 bits, BCD sum digit (0-9).
REQ-011 Port `carry`: output, 1 bit, decimal carry out (set when total >= 10).
REQ-012 Port `err`: output, 1 bit, set when `a` > 9 or `b` > 9 for the registered operation.

Function
REQ-013 On a clk edge with `in_valid`=1 and `rst`=0, the block SHALL register the result of a+b+carry_in computed as a 5-bit binary total T.
REQ-014 If T <= 9, the block SHALL set `sum`=T[3:0] and `carry`=0.
REQ-015 If T >= 10 (10..19), the block SHALL set `sum`=(T+6)[3:0] and `carry`=1, which is equivalent to `sum`=T-10.
REQ-016 If `a` > 9 or `b` > 9, the block SHALL set `err`=1, `sum`=0 and `carry`=0; otherwise `err`=0.
REQ-017 Latency SHALL be exactly 1 cycle: `out_valid` is high in the cycle after `in_valid` is sampled high.
REQ-018 The block SHALL accept one operation per cycle with no backpressure; back-to-back `in_valid` yields back-to-back `out_valid`.
REQ-019 When `in_valid`=0, `out_valid` SHALL drop to 0 on the next edge, and `sum`, `carry` and `err` SHALL hold their last values.
REQ-020 Maximum legal total is 9+9+1=19, so `sum` SHALL never exceed 9 when `err`=0.
REQ-021 Outputs SHALL come directly from flops, with no combinational input-to-output path.

Reset
REQ-022 When `rst`=1 at a clk edge, the block SHALL drive `out_valid`=0, `sum`=0, `carry`=0 and `err`=0, overriding `in_valid`.
REQ-023 If `rst` is asserted in the same cycle as `in_valid`, that operation SHALL be discarded.
REQ-024 The first operation after reset deasserts SHALL be accepted in the first cycle `rst`=0.

Structure
REQ-025 Package `bcd_pkg` SHALL hold the constants BCD_MAX=4'd9, BCD_CORR=4'd6 and DIGIT_W=4.
REQ-026 The combinational digit add and correction SHALL live in sub-module `bcd_digit_add` (ports a, b, cin, sum, cout, err).
REQ-027 `bcd_adder` SHALL contain only the output registers and the valid pipeline around `bcd_digit_add`.

Verification
REQ-028 Reset, then a=0, b=0, cin=0 with in_valid=1 -> next cycle out_valid=1, sum=0, carry=0, err=0.
REQ-029 Drive the sequence (a,b,cin) = (5,9,0), (3,3,1), (4,5,0), (8,2,0), (9,9,1) back-to-back:
- Required results in order: sum/carry = 4/1, 7/0, 9/0, 0/1, 9/1.
- out_valid SHALL stay high for 5 consecutive cycles.
REQ-030 Drive a=12, b=3, cin=0 -> err=1, sum=0, carry=0.
REQ-031 Assert rst together with in_valid=1 (a=9, b=9) -> next cycle out_valid=0 and sum=0.
REQ-032 Apply in_valid=1 then in_valid=0 -> out_valid pulses for exactly 1 cycle and sum holds its value.
REQ-033 Run an exhaustive sweep over a,b in 0..9 and cin in 0..1 -> 10*carry+sum SHALL equal a+b+cin for all 200 cases.
